// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID fields, forwarding sources from EX/MEM and MEM/WB,
// and the registered/forwarded EX-side outputs. The pipeline driver is master.
interface id_ex_stage_if #(
  parameter int XLEN = 32,
  parameter int REGW = 5
);
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [REGW-1:0] id_rs1;
  logic [REGW-1:0] id_rs2;
  logic            id_use_rs1;
  logic            id_use_rs2;
  logic [REGW-1:0] id_rd;
  logic [XLEN-1:0] id_rdata1;
  logic [XLEN-1:0] id_rdata2;
  logic [XLEN-1:0] id_imm;
  logic            id_alusrc;
  logic [3:0]      id_aluctl;
  logic            id_memread;
  logic            id_memwrite;
  logic            id_regwrite;
  logic            id_memtoreg;
  logic            id_branch;
  logic            flush;

  logic            exmem_regwrite;
  logic [REGW-1:0] exmem_rd;
  logic [XLEN-1:0] exmem_aluout;
  logic            memwb_regwrite;
  logic [REGW-1:0] memwb_rd;
  logic [XLEN-1:0] memwb_wdata;

  logic            stall;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  logic [REGW-1:0] ex_rd;
  logic [XLEN-1:0] ex_a;
  logic [XLEN-1:0] ex_b;
  logic [XLEN-1:0] ex_store_data;
  logic [3:0]      ex_aluctl;
  logic            ex_memread;
  logic            ex_memwrite;
  logic            ex_regwrite;
  logic            ex_memtoreg;
  logic            ex_branch;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_rdata1, id_rdata2, id_imm, id_alusrc, id_aluctl, id_memread,
           id_memwrite, id_regwrite, id_memtoreg, id_branch, flush,
           exmem_regwrite, exmem_rd, exmem_aluout,
           memwb_regwrite, memwb_rd, memwb_wdata,
    input  stall, ex_valid, ex_pc, ex_imm, ex_rd, ex_a, ex_b, ex_store_data,
           ex_aluctl, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg, ex_branch
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_rdata1, id_rdata2, id_imm, id_alusrc, id_aluctl, id_memread,
           id_memwrite, id_regwrite, id_memtoreg, id_branch, flush,
           exmem_regwrite, exmem_rd, exmem_aluout,
           memwb_regwrite, memwb_rd, memwb_wdata,
    output stall, ex_valid, ex_pc, ex_imm, ex_rd, ex_a, ex_b, ex_store_data,
           ex_aluctl, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg, ex_branch
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX register with EX-side operand forwarding and load-use hazard detection.
// Latency: 1 cycle ID->EX; ALU operands are combinational from the register and forwards.
// Backpressure: combinational stall freezes PC/IF-ID and inserts a bubble; flush also bubbles.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input logic         clock,
  input logic         reset,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       memtoreg;
    logic       branch;
    logic       alusrc;
    logic [3:0] aluctl;
  } ctl_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [REGW-1:0] rd;
  } dat_t;

  logic            valid_q;
  ctl_t            ctl_q;
  ctl_t            ctl_d;
  dat_t            dat_q;
  dat_t            dat_d;
  logic            stall_c;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // Writer hit on a source register; x0 is hardwired and never matches.
  function automatic logic hit(input logic we, input logic [REGW-1:0] wr_rd,
                               input logic [REGW-1:0] rs);
    return we && (wr_rd != '0) && (wr_rd == rs);
  endfunction

  always_comb begin
    stall_c = valid_q && ctl_q.memread && (dat_q.rd != '0) && bus.id_valid &&
              ((bus.id_use_rs1 && (bus.id_rs1 == dat_q.rd)) ||
               (bus.id_use_rs2 && (bus.id_rs2 == dat_q.rd)));
  end

  // The register file has no write-through, so a same-cycle WB write is picked up here.
  always_comb begin
    ctl_d          = '0;
    ctl_d.memread  = bus.id_memread;
    ctl_d.memwrite = bus.id_memwrite;
    ctl_d.regwrite = bus.id_regwrite;
    ctl_d.memtoreg = bus.id_memtoreg;
    ctl_d.branch   = bus.id_branch;
    ctl_d.alusrc   = bus.id_alusrc;
    ctl_d.aluctl   = bus.id_aluctl;

    dat_d        = '0;
    dat_d.pc     = bus.id_pc;
    dat_d.imm    = bus.id_imm;
    dat_d.rs1    = bus.id_rs1;
    dat_d.rs2    = bus.id_rs2;
    dat_d.rd     = bus.id_rd;
    dat_d.rdata1 = hit(bus.memwb_regwrite, bus.memwb_rd, bus.id_rs1) ?
                   bus.memwb_wdata : bus.id_rdata1;
    dat_d.rdata2 = hit(bus.memwb_regwrite, bus.memwb_rd, bus.id_rs2) ?
                   bus.memwb_wdata : bus.id_rdata2;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctl_q   <= '0;
      dat_q   <= '0;
    end else if (bus.flush || stall_c) begin
      valid_q        <= 1'b0;
      ctl_q.memread  <= 1'b0;
      ctl_q.memwrite <= 1'b0;
      ctl_q.regwrite <= 1'b0;
      ctl_q.branch   <= 1'b0;
    end else begin
      valid_q <= bus.id_valid;
      ctl_q   <= ctl_d;
      dat_q   <= dat_d;
    end
  end

  // The youngest producer (EX/MEM) wins over MEM/WB.
  always_comb begin
    fwd_rs1 = dat_q.rdata1;
    if (hit(bus.exmem_regwrite, bus.exmem_rd, dat_q.rs1)) begin
      fwd_rs1 = bus.exmem_aluout;
    end else if (hit(bus.memwb_regwrite, bus.memwb_rd, dat_q.rs1)) begin
      fwd_rs1 = bus.memwb_wdata;
    end

    fwd_rs2 = dat_q.rdata2;
    if (hit(bus.exmem_regwrite, bus.exmem_rd, dat_q.rs2)) begin
      fwd_rs2 = bus.exmem_aluout;
    end else if (hit(bus.memwb_regwrite, bus.memwb_rd, dat_q.rs2)) begin
      fwd_rs2 = bus.memwb_wdata;
    end
  end

  assign bus.stall         = stall_c;
  assign bus.ex_valid      = valid_q;
  assign bus.ex_pc         = dat_q.pc;
  assign bus.ex_imm        = dat_q.imm;
  assign bus.ex_rd         = dat_q.rd;
  assign bus.ex_a          = fwd_rs1;
  assign bus.ex_b          = ctl_q.alusrc ? dat_q.imm : fwd_rs2;
  assign bus.ex_store_data = fwd_rs2;
  assign bus.ex_aluctl     = ctl_q.aluctl;
  assign bus.ex_memread    = ctl_q.memread;
  assign bus.ex_memwrite   = ctl_q.memwrite;
  assign bus.ex_regwrite   = ctl_q.regwrite;
  assign bus.ex_memtoreg   = ctl_q.memtoreg;
  assign bus.ex_branch     = ctl_q.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scenarios plus random traffic against an instruction-level model of the EX slot.
module tb_id_ex_stage;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  id_ex_stage_if #(.XLEN(32), .REGW(5)) bus ();

  id_ex_stage #(.XLEN(32), .REGW(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // The instruction currently sitting in EX, as the model sees it.
  typedef struct {
    bit          valid;
    logic [31:0] pc, imm, v1, v2;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  aluctl;
    bit          alusrc, memread, memwrite, regwrite, memtoreg, branch;
  } ex_rec_t;

  ex_rec_t m;
  bit      known;  // data fields are defined (not after a bubble)

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit writes(input logic we, input logic [4:0] rd, input logic [4:0] rs);
    return (we == 1'b1) && (rd != 5'd0) && (rd == rs);
  endfunction

  function automatic logic [31:0] forwarded(input logic [4:0] rs, input logic [31:0] held);
    if (writes(bus.exmem_regwrite, bus.exmem_rd, rs)) return bus.exmem_aluout;
    if (writes(bus.memwb_regwrite, bus.memwb_rd, rs)) return bus.memwb_wdata;
    return held;
  endfunction

  function automatic bit exp_stall();
    return m.valid && m.memread && (m.rd != 5'd0) && (bus.id_valid == 1'b1) &&
           ((bus.id_use_rs1 && bus.id_rs1 == m.rd) || (bus.id_use_rs2 && bus.id_rs2 == m.rd));
  endfunction

  task automatic compare_all();
    logic [31:0] f2;
    check("stall", bus.stall, exp_stall());
    check("ex_valid", bus.ex_valid, m.valid);
    check("ex_memread", bus.ex_memread, m.memread);
    check("ex_memwrite", bus.ex_memwrite, m.memwrite);
    check("ex_regwrite", bus.ex_regwrite, m.regwrite);
    check("ex_branch", bus.ex_branch, m.branch);
    if (known) begin
      f2 = forwarded(m.rs2, m.v2);
      check("ex_pc", bus.ex_pc, m.pc);
      check("ex_imm", bus.ex_imm, m.imm);
      check("ex_rd", bus.ex_rd, m.rd);
      check("ex_aluctl", bus.ex_aluctl, m.aluctl);
      check("ex_memtoreg", bus.ex_memtoreg, m.memtoreg);
      check("ex_a", bus.ex_a, forwarded(m.rs1, m.v1));
      check("ex_store_data", bus.ex_store_data, f2);
      check("ex_b", bus.ex_b, m.alusrc ? m.imm : f2);
    end
  endtask

  task automatic model_step(input bit st);
    if (reset) begin
      m = '{default: 0};
      known = 1'b1;
    end else if (bus.flush || st) begin
      m.valid = 0; m.memread = 0; m.memwrite = 0; m.regwrite = 0; m.branch = 0;
      known = 1'b0;
    end else begin
      m.valid    = bus.id_valid;
      m.pc       = bus.id_pc;
      m.imm      = bus.id_imm;
      m.rs1      = bus.id_rs1;
      m.rs2      = bus.id_rs2;
      m.rd       = bus.id_rd;
      m.v1       = writes(bus.memwb_regwrite, bus.memwb_rd, bus.id_rs1) ? bus.memwb_wdata : bus.id_rdata1;
      m.v2       = writes(bus.memwb_regwrite, bus.memwb_rd, bus.id_rs2) ? bus.memwb_wdata : bus.id_rdata2;
      m.aluctl   = bus.id_aluctl;
      m.alusrc   = bus.id_alusrc;
      m.memread  = bus.id_memread;
      m.memwrite = bus.id_memwrite;
      m.regwrite = bus.id_regwrite;
      m.memtoreg = bus.id_memtoreg;
      m.branch   = bus.id_branch;
      known = 1'b1;
    end
  endtask

  // One cycle: check settled outputs, take the edge, advance the model.
  task automatic tick();
    bit st;
    #1;
    compare_all();
    st = exp_stall();
    @(posedge clock);
    model_step(st);
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    bus.id_valid = 0; bus.id_pc = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
    bus.id_use_rs1 = 0; bus.id_use_rs2 = 0; bus.id_rd = 0;
    bus.id_rdata1 = 0; bus.id_rdata2 = 0; bus.id_imm = 0; bus.id_alusrc = 0;
    bus.id_aluctl = 0; bus.id_memread = 0; bus.id_memwrite = 0; bus.id_regwrite = 0;
    bus.id_memtoreg = 0; bus.id_branch = 0; bus.flush = 0;
    bus.exmem_regwrite = 0; bus.exmem_rd = 0; bus.exmem_aluout = 0;
    bus.memwb_regwrite = 0; bus.memwb_rd = 0; bus.memwb_wdata = 0;
  endtask

  task automatic rand_inputs();
    logic [3:0] ops [6];
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
    reset = ($urandom_range(0, 49) == 0);
    bus.id_valid = ($urandom_range(0, 9) != 0);
    bus.id_pc = $urandom; bus.id_imm = $urandom;
    bus.id_rs1 = 5'($urandom_range(0, 7)); bus.id_rs2 = 5'($urandom_range(0, 7));
    bus.id_rd = 5'($urandom_range(0, 7));
    bus.id_use_rs1 = $urandom_range(0, 1); bus.id_use_rs2 = $urandom_range(0, 1);
    bus.id_rdata1 = $urandom; bus.id_rdata2 = $urandom;
    bus.id_alusrc = $urandom_range(0, 1);
    bus.id_aluctl = ops[$urandom_range(0, 5)];
    bus.id_memread = ($urandom_range(0, 2) == 0); bus.id_memwrite = $urandom_range(0, 1);
    bus.id_regwrite = $urandom_range(0, 1); bus.id_memtoreg = $urandom_range(0, 1);
    bus.id_branch = $urandom_range(0, 1);
    bus.flush = ($urandom_range(0, 9) == 0);
    bus.exmem_regwrite = $urandom_range(0, 1); bus.exmem_rd = 5'($urandom_range(0, 7));
    bus.exmem_aluout = $urandom;
    bus.memwb_regwrite = $urandom_range(0, 1); bus.memwb_rd = 5'($urandom_range(0, 7));
    bus.memwb_wdata = $urandom;
  endtask

  initial begin
    clear_inputs();
    m = '{default: 0};
    known = 1'b0;
    reset = 1'b1;
    repeat (3) begin
      @(posedge clock);
      model_step(1'b0);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_ex_valid", bus.ex_valid, 0);
    check("rst_ex_regwrite", bus.ex_regwrite, 0);
    check("rst_ex_aluctl", bus.ex_aluctl, 0);
    check("rst_stall", bus.stall, 0);
    tick();

    // EX/MEM forward into ex_a
    clear_inputs();
    bus.id_valid = 1; bus.id_rs1 = 5; bus.id_use_rs1 = 1; bus.id_rdata1 = 32'h1;
    bus.id_aluctl = 4'b0010; bus.id_regwrite = 1; bus.id_rd = 9;
    tick();
    clear_inputs();
    bus.exmem_regwrite = 1; bus.exmem_rd = 5; bus.exmem_aluout = 32'h10;
    #1; check("fwd_exmem_a", bus.ex_a, 32'h10);
    tick();

    // EX/MEM beats MEM/WB; x0 never forwarded
    clear_inputs();
    bus.id_valid = 1; bus.id_rs1 = 3; bus.id_use_rs1 = 1; bus.id_rdata1 = 32'h33;
    tick();
    clear_inputs();
    bus.exmem_regwrite = 1; bus.exmem_rd = 3; bus.exmem_aluout = 32'hAA;
    bus.memwb_regwrite = 1; bus.memwb_rd = 3; bus.memwb_wdata = 32'hBB;
    #1; check("fwd_prio_a", bus.ex_a, 32'hAA);
    bus.exmem_regwrite = 0;
    #1; check("fwd_memwb_a", bus.ex_a, 32'hBB);
    tick();
    clear_inputs();
    bus.id_valid = 1; bus.id_rs1 = 0; bus.id_rdata1 = 32'h1234;
    bus.memwb_regwrite = 1; bus.memwb_rd = 0; bus.memwb_wdata = 32'hBB;
    tick();
    clear_inputs();
    bus.exmem_regwrite = 1; bus.exmem_rd = 0; bus.exmem_aluout = 32'hAA;
    bus.memwb_regwrite = 1; bus.memwb_rd = 0; bus.memwb_wdata = 32'hBB;
    #1; check("fwd_x0_a", bus.ex_a, 32'h1234);
    tick();

    // load-use: stall one cycle, bubble, then MEM/WB forward into ex_b
    clear_inputs();
    bus.id_valid = 1; bus.id_memread = 1; bus.id_regwrite = 1; bus.id_memtoreg = 1; bus.id_rd = 7;
    tick();
    clear_inputs();
    bus.id_valid = 1; bus.id_use_rs2 = 1; bus.id_rs2 = 7; bus.id_rd = 8; bus.id_regwrite = 1;
    #1; check("lu_stall", bus.stall, 1);
    tick();
    bus.exmem_regwrite = 1; bus.exmem_rd = 7; bus.exmem_aluout = 32'h100;
    #1; check("lu_stall_drop", bus.stall, 0);
    check("lu_bubble", bus.ex_valid, 0);
    tick();
    bus.exmem_regwrite = 0;
    bus.memwb_regwrite = 1; bus.memwb_rd = 7; bus.memwb_wdata = 32'hCAFE;
    #1; check("lu_ex_b", bus.ex_b, 32'hCAFE);
    check("lu_ex_valid", bus.ex_valid, 1);
    tick();

    // flush kills the ID instruction
    clear_inputs();
    bus.id_valid = 1; bus.id_regwrite = 1; bus.id_rd = 2; bus.flush = 1;
    tick();
    clear_inputs();
    #1; check("flush_valid", bus.ex_valid, 0);
    check("flush_regwrite", bus.ex_regwrite, 0);
    tick();

    // capture-time bypass from MEM/WB
    clear_inputs();
    bus.id_valid = 1; bus.id_rs1 = 4; bus.id_use_rs1 = 1; bus.id_rdata1 = 0;
    bus.memwb_regwrite = 1; bus.memwb_rd = 4; bus.memwb_wdata = 32'h55;
    tick();
    clear_inputs();
    #1; check("cap_bypass_a", bus.ex_a, 32'h55);
    tick();

    // reset while stalling
    clear_inputs();
    bus.id_valid = 1; bus.id_memread = 1; bus.id_rd = 6;
    tick();
    clear_inputs();
    bus.id_valid = 1; bus.id_use_rs1 = 1; bus.id_rs1 = 6;
    #1; check("rs_stall", bus.stall, 1);
    reset = 1;
    tick();
    reset = 0;
    #1; check("rs_stall_clr", bus.stall, 0);
    check("rs_empty", bus.ex_valid, 0);
    tick();

    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      tick();
    end
    reset = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
